// File: rtl/openddr_bank_scheduler.sv
// Per-bank DDR command scheduler: open-page policy, per-bank tRCD/tRAS/tRP timers,
// periodic refresh (PREA -> REF -> tRFC), one registered command per cycle.
module openddr_bank_scheduler #(
  parameter int BANK_WIDTH = 3,
  parameter int ROW_WIDTH  = 16,
  parameter int COL_WIDTH  = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int T_RCD      = 4,
  parameter int T_RAS      = 8,
  parameter int T_RP       = 3,
  parameter int T_RFC      = 10,
  parameter int T_REFI     = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [BANK_WIDTH-1:0]       req_bank,
  input  logic [ROW_WIDTH-1:0]        req_row,
  input  logic [COL_WIDTH-1:0]        req_col,
  output logic                        cmd_valid,
  output logic [2:0]                  cmd_type,
  output logic [BANK_WIDTH-1:0]       cmd_bank,
  output logic [ROW_WIDTH-1:0]        cmd_addr,
  output logic [(1<<BANK_WIDTH)-1:0]  bank_open,
  output logic                        ref_busy
);
  localparam int NB = 1 << BANK_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RCD_LD  = CNT_WIDTH'(T_RCD - 1);
  localparam logic [CNT_WIDTH-1:0] RAS_LD  = CNT_WIDTH'(T_RAS - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LD   = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] RFC_LD  = CNT_WIDTH'(T_RFC - 1);
  localparam logic [CNT_WIDTH-1:0] REFI_LD = CNT_WIDTH'(T_REFI - 1);

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_DECIDE, S_PRE, S_ACT, S_CAS, S_PREA, S_REF, S_RFC} state_t;

  state_t                  r_state;
  logic                    r_live;
  logic                    r_ref_pend;
  logic [CNT_WIDTH-1:0]    r_refcnt;
  logic                    r_wr;
  logic [BANK_WIDTH-1:0]   r_bank;
  logic [ROW_WIDTH-1:0]    r_row;
  logic [COL_WIDTH-1:0]    r_col;
  logic [CNT_WIDTH-1:0]    r_rcd [NB];
  logic [CNT_WIDTH-1:0]    r_ras [NB];
  logic [CNT_WIDTH-1:0]    r_rp  [NB];
  logic [CNT_WIDTH-1:0]    r_rfc;
  logic [ROW_WIDTH-1:0]    r_open_row [NB];
  logic [NB-1:0]           r_bank_open;
  logic                    r_cmd_valid;
  logic [2:0]              r_cmd_type;
  logic [BANK_WIDTH-1:0]   r_cmd_bank;
  logic [ROW_WIDTH-1:0]    r_cmd_addr;

  logic w_any_ras, w_any_rp, w_accept, w_refcnt_zero, w_hit;
  logic w_iss_pre, w_iss_act, w_iss_cas, w_iss_prea, w_iss_ref;

  always_comb begin
    w_any_ras = 1'b0;
    w_any_rp  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      w_any_ras = w_any_ras | (r_ras[i] != '0);
      w_any_rp  = w_any_rp  | (r_rp[i]  != '0);
    end
  end

  assign w_refcnt_zero = (r_refcnt == '0);
  // r_live keeps ready low while reset is held, since the other terms look idle then
  assign req_ready     = r_live && (r_state == S_IDLE) && !r_ref_pend && !w_refcnt_zero;
  assign w_accept      = req_valid && req_ready;
  assign w_hit         = r_bank_open[r_bank] && (r_open_row[r_bank] == r_row);

  assign w_iss_pre  = (r_state == S_PRE)  && (r_ras[r_bank] == '0);
  assign w_iss_act  = (r_state == S_ACT)  && (r_rp[r_bank]  == '0);
  assign w_iss_cas  = (r_state == S_CAS)  && (r_rcd[r_bank] == '0);
  assign w_iss_prea = (r_state == S_PREA) && !w_any_ras;
  assign w_iss_ref  = (r_state == S_REF)  && !w_any_rp;

  assign ref_busy  = r_ref_pend || (r_state == S_PREA) || (r_state == S_REF) || (r_state == S_RFC);
  assign cmd_valid = r_cmd_valid;
  assign cmd_type  = r_cmd_type;
  assign cmd_bank  = r_cmd_bank;
  assign cmd_addr  = r_cmd_addr;
  assign bank_open = r_bank_open;

  // Timers load T-1 on their command and saturate at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        r_rcd[i] <= '0;
        r_ras[i] <= '0;
        r_rp[i]  <= '0;
      end
      r_rfc <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_iss_act && (r_bank == BANK_WIDTH'(i))) begin
          r_rcd[i] <= RCD_LD;
          r_ras[i] <= RAS_LD;
        end else begin
          if (r_rcd[i] != '0) r_rcd[i] <= r_rcd[i] - ONE;
          if (r_ras[i] != '0) r_ras[i] <= r_ras[i] - ONE;
        end
        if (w_iss_prea || (w_iss_pre && (r_bank == BANK_WIDTH'(i)))) r_rp[i] <= RP_LD;
        else if (r_rp[i] != '0)                                        r_rp[i] <= r_rp[i] - ONE;
      end
      if (w_iss_ref)          r_rfc <= RFC_LD;
      else if (r_rfc != '0)   r_rfc <= r_rfc - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_ref_pend  <= 1'b0;
      r_refcnt    <= REFI_LD;
      r_wr        <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_bank_open <= '0;
      for (int i = 0; i < NB; i++) r_open_row[i] <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= C_NOP;
      r_cmd_bank  <= '0;
      r_cmd_addr  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= C_NOP;
      r_cmd_bank  <= '0;
      r_cmd_addr  <= '0;
      r_refcnt    <= w_refcnt_zero ? REFI_LD : (r_refcnt - ONE);
      case (r_state)
        S_IDLE: begin
          if (r_ref_pend) begin
            r_state <= (|r_bank_open) ? S_PREA : S_REF;
          end else if (w_accept) begin
            r_wr    <= req_write;
            r_bank  <= req_bank;
            r_row   <= req_row;
            r_col   <= req_col;
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (w_hit)                     r_state <= S_CAS;
          else if (r_bank_open[r_bank])  r_state <= S_PRE;
          else                           r_state <= S_ACT;
        end
        S_PRE: if (w_iss_pre) begin
          r_cmd_valid          <= 1'b1;
          r_cmd_type           <= C_PRE;
          r_cmd_bank           <= r_bank;
          r_bank_open[r_bank]  <= 1'b0;
          r_state              <= S_ACT;
        end
        S_ACT: if (w_iss_act) begin
          r_cmd_valid          <= 1'b1;
          r_cmd_type           <= C_ACT;
          r_cmd_bank           <= r_bank;
          r_cmd_addr           <= r_row;
          r_bank_open[r_bank]  <= 1'b1;
          r_open_row[r_bank]   <= r_row;
          r_state              <= S_CAS;
        end
        S_CAS: if (w_iss_cas) begin
          r_cmd_valid <= 1'b1;
          r_cmd_type  <= r_wr ? C_WR : C_RD;
          r_cmd_bank  <= r_bank;
          r_cmd_addr  <= ROW_WIDTH'(r_col);
          r_state     <= S_IDLE;
        end
        S_PREA: if (w_iss_prea) begin
          r_cmd_valid <= 1'b1;
          r_cmd_type  <= C_PREA;
          r_bank_open <= '0;
          r_state     <= S_REF;
        end
        S_REF: if (w_iss_ref) begin
          r_cmd_valid <= 1'b1;
          r_cmd_type  <= C_REF;
          r_state     <= S_RFC;
        end
        S_RFC: if (r_rfc == '0) begin
          r_ref_pend <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A new expiry outranks the clear at the end of tRFC
      if (w_refcnt_zero) r_ref_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_openddr_bank_scheduler.sv
// Random request stream against a timestamp model of the scheduler: each accepted request
// or refresh is turned into absolute command cycles from the DDR timing rules.
module tb_openddr_bank_scheduler;
  localparam int BW = 3, RW = 16, CW = 10, NB = 8;
  localparam int T_RCD = 4, T_RAS = 8, T_RP = 3, T_RFC = 10, T_REFI = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [BW-1:0] req_bank = '0;
  logic [RW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic          req_ready, cmd_valid, ref_busy;
  logic [2:0]    cmd_type;
  logic [BW-1:0] cmd_bank;
  logic [RW-1:0] cmd_addr;
  logic [NB-1:0] bank_open;

  always #5 clk = ~clk;

  openddr_bank_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .bank_open(bank_open), .ref_busy(ref_busy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { int t; int typ; int bank; int addr; } cmd_t;
  cmd_t          q[$];
  int            t_act[NB], t_pre[NB], m_row[NB];
  bit            m_open[NB];
  int            free_at, ref_lo, ref_hi, k;
  logic [NB-1:0] exp_open;
  bit            exp_ready, last_act, did_mid_reset;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push(input int t, input int typ, input int bank, input int addr);
    cmd_t c;
    c.t = t; c.typ = typ; c.bank = bank; c.addr = addr;
    q.push_back(c);
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int b = 0; b < NB; b++) begin
      t_act[b] = -1000; t_pre[b] = -1000; m_open[b] = 0; m_row[b] = 0;
    end
    free_at = 0; ref_lo = -1; ref_hi = -1; k = 0; exp_open = '0;
  endfunction

  // Request accepted at edge n: DECIDE at n+1, first command no earlier than n+2
  function automatic void accept(input int n, input bit wr, input int b, input int row, input int col);
    int act, pre, cas;
    if (m_open[b] && m_row[b] == row) begin
      cas = imax(n + 2, t_act[b] + T_RCD);
    end else begin
      if (m_open[b]) begin
        pre = imax(n + 2, t_act[b] + T_RAS);
        push(pre, 4, b, 0);
        t_pre[b] = pre;
        act = pre + T_RP;
      end else begin
        act = imax(n + 2, t_pre[b] + T_RP);
      end
      push(act, 1, b, row);
      t_act[b] = act; m_open[b] = 1; m_row[b] = row;
      cas = act + T_RCD;
    end
    push(cas, wr ? 3 : 2, b, col);
    free_at = cas;
  endfunction

  // Refresh due at edge p starts once the controller is idle
  function automatic void sched_ref(input int p);
    int e, a, r, mx;
    bit any;
    e = imax(p, free_at) + 1;
    ref_lo = p;
    any = 0;
    for (int b = 0; b < NB; b++) any |= m_open[b];
    mx = e + 1;
    if (any) begin
      for (int b = 0; b < NB; b++) mx = imax(mx, t_act[b] + T_RAS);
      a = mx;
      push(a, 5, 0, 0);
      for (int b = 0; b < NB; b++) begin t_pre[b] = a; m_open[b] = 0; end
      r = a + T_RP;
    end else begin
      for (int b = 0; b < NB; b++) mx = imax(mx, t_pre[b] + T_RP);
      r = mx;
    end
    push(r, 6, 0, 0);
    free_at = r + T_RFC;
    ref_hi  = free_at;
  endfunction

  task automatic check_cycle();
    cmd_t c;
    logic [22:0] exp_cmd;
    exp_cmd = '0;
    last_act = 0;
    if (q.size() > 0 && q[0].t == k) begin
      c = q.pop_front();
      exp_cmd = {1'b1, 3'(c.typ), 3'(c.bank), 16'(c.addr)};
      if (c.typ == 1) begin exp_open[c.bank] = 1'b1; last_act = 1; end
      if (c.typ == 4) exp_open[c.bank] = 1'b0;
      if (c.typ == 5) exp_open = '0;
    end
    chk("cmd", {cmd_valid, cmd_type, cmd_bank, cmd_addr}, exp_cmd);
    chk("bank_open", bank_open, exp_open);
    chk("ref_busy", ref_busy, (k >= ref_lo && k < ref_hi));
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {cmd_valid, cmd_type, cmd_bank, cmd_addr, bank_open, ref_busy, req_ready}, '0);
  endtask

  int d_bank[5] = '{2, 2, 2, 6, 6};
  int d_row[5]  = '{'h12, 'h12, 'h34, 1, 2};
  int d_col[5]  = '{5, 9, 7, 3, 4};
  int dir_idx = 0;

  initial begin
    model_reset();
    did_mid_reset = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    exp_ready = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      k++;
      if (req_valid && exp_ready) begin
        accept(k, req_write, int'(req_bank), int'(req_row), int'(req_col));
        if (dir_idx < 5) dir_idx++;
      end
      if (k % T_REFI == 0) sched_ref(k);
      @(negedge clk);
      check_cycle();
      // Reset between ACT and its CAS: the pending RD/WR must never appear
      if (!did_mid_reset && cyc > 300 && last_act && q.size() > 0 && (q[0].typ == 2 || q[0].typ == 3)) begin
        did_mid_reset = 1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset_hold");
        rst_n = 1'b1;
        model_reset();
        dir_idx = 0;
      end
      exp_ready = (k >= 1) && (k >= free_at) && ((k + 1) % T_REFI != 0);
      chk("req_ready", req_ready, exp_ready);
      if (dir_idx < 5) begin
        req_valid = 1'b1; req_write = 1'b0;
        req_bank  = BW'(d_bank[dir_idx]);
        req_row   = RW'(d_row[dir_idx]);
        req_col   = CW'(d_col[dir_idx]);
      end else begin
        req_valid = ($urandom_range(0, 3) != 0) || ((k + 1) % T_REFI == 0);
        req_write = 1'($urandom_range(0, 1));
        req_bank  = BW'($urandom_range(0, 3));
        req_row   = RW'($urandom_range(0, 2));
        req_col   = CW'($urandom_range(0, 1023));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
